time_alarm_core: RTL
====================

// Module: time_alarm_core
// PURPOSE
// - Time-of-day keeper with set mode and alarm; directly upstream of the 4-digit multiplexed 7-seg display stage.
// - Produces four BCD digits (HH:MM) for the display, per-digit blink mask and an alarm ring output.
// - Buttons arrive as debounced single-cycle pulses in the clk domain.
// PARAMETERS
// - CLK_HZ      100_000_000  clk cycles per second; prescaler terminal count = CLK_HZ-1
// - RING_SECS   60           max seconds alarm_ring stays high if not silenced
// - SNOOZE_MIN  5            snooze delay in minutes (used only when SNOOZE_EN defined)
// PORTS
// - clk        in   1  system clock, single clock domain
// - rst        in   1  reset, asynchronous, active-low
// - en         in   1  1 = timekeeping runs; 0 = prescaler and time frozen (FSM and buttons still live)
// - mode_btn   in   1  pulse: advance set-mode FSM
// - up_btn     in   1  pulse: increment selected field
// - down_btn   in   1  pulse: decrement selected field
// - alarm_en   in   1  level: alarm armed
// - digit3     out  4  hours tens (0-2)
// - digit2     out  4  hours units (0-9)
// - digit1     out  4  minutes tens (0-5)
// - digit0     out  4  minutes units (0-9)
// - blink      out  4  1 per digit being edited (bit3 = digit3)
// - alarm_ring out  1  alarm sounding
// - sec_tick   out  1  one-cycle pulse per elapsed second (only while en=1)
// BEHAVIOUR
// - Reset: time 00:00:00, alarm 00:00, prescaler 0, FSM=RUN; all outputs 0.
// - Prescaler counts 0..CLK_HZ-1 while en=1; sec_tick asserted in the cycle it wraps; holds value when en=0.
// - Time regs: seconds 0-59 (internal), minutes 0-59, hours 0-23, all BCD; digit outputs are registered, 1-cycle latency after any change.
// - RUN: on sec_tick advance seconds; 59->0 carries to minutes, 59->0 carries to hours; 23:59:59 -> 00:00:00.
// - FSM states: RUN -> SET_HR -> SET_MIN -> SET_AL_HR -> SET_AL_MIN -> RUN, one step per mode_btn.
// - SET_*: time not advanced (sec_tick still pulses). up/down modify selected field with wrap: hours 23<->00, minutes 59<->00; no carry between fields.
// - Leaving SET_MIN clears seconds to 0. Leaving SET_AL_MIN changes no time reg.
// - Digits show clock time in RUN/SET_HR/SET_MIN, alarm time in SET_AL_HR/SET_AL_MIN.
// - blink = 4'b1100 in SET_HR/SET_AL_HR, 4'b0011 in SET_MIN/SET_AL_MIN, 4'b0000 in RUN.
// - Same-cycle pulses: mode_btn wins, up/down ignored; up_btn and down_btn together = no-op.
// - Alarm trigger: FSM=RUN, alarm_en=1, sec_tick carries time to HH:MM:00 equal to alarm HH:MM -> alarm_ring=1 next cycle.
// - Ring ends: after RING_SECS sec_ticks, alarm_en=0, or any button pulse. A silencing pulse is consumed (no FSM step, no edit).
// - Leaving RUN via mode_btn not possible while ringing (pulse silences instead).
// - Async reset mid-ring or mid-edit: immediate return to reset state, edits discarded.
// CONFIGURATION
// - SNOOZE_EN defined: while ringing, up_btn silences and loads a snooze counter = SNOOZE_MIN; decremented on each minute carry in RUN; at 0 ring re-asserts (RING_SECS timeout again). mode_btn/down_btn or alarm_en=0 silence and cancel snooze. Snooze count clears on reset or on entering SET_HR.
// - SNOOZE_EN undefined: no snooze logic; any button pulse silences; SNOOZE_MIN unused.
// TESTING (CLK_HZ=10, RING_SECS=3)
// - Reset then en=1 for 600 s -> digits 0,0,1,0 (00:10); sec_tick every 10 clk; en=0 for 50 clk -> digits/seconds unchanged.
// - Preload 23:59:59 via set mode + ticks -> one sec_tick later digits 0,0,0,0; 09:59:59 -> 10:00.
// - mode_btn x1, down_btn x1 -> hours 23, blink=1100; mode_btn, up_btn x61 -> minutes 01, no hour change; mode_btn x3 -> RUN, seconds=0.
// - Alarm 07:30, alarm_en=1, time reaches 07:30:00 -> alarm_ring=1 next cycle, drops after 3 sec_ticks; repeat with down_btn pulse -> drops next cycle, FSM stays RUN.
// - Same-cycle mode_btn+up_btn in SET_HR -> state SET_MIN, hours unchanged; up+down together -> no change.
// - SNOOZE_EN, SNOOZE_MIN=2: up_btn during ring -> ring 0, re-asserts at 07:32:00; rst low mid-ring -> all outputs 0 immediately.

Source files
------------

// File: rtl/time_alarm_core.sv
// time_alarm_core: BCD HH:MM clock with set mode, alarm and ring timeout.
// Ports: clk, rst (async, active-low), en, mode/up/down_btn pulses, alarm_en;
//   digit3..digit0 BCD HH:MM, blink per-digit edit mask, alarm_ring, sec_tick.
//   Define SNOOZE_EN to add the snooze counter (SNOOZE_MIN minutes).
module time_alarm_core #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode_btn,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic       alarm_en,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] blink,
    output logic       alarm_ring,
    output logic       sec_tick
);
    localparam int PW = $clog2(CLK_HZ + 1);
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
    localparam int RW = $clog2(RING_SECS + 1);
    localparam logic [RW-1:0] RMAX = RW'(RING_SECS - 1);

    typedef enum logic [2:0] {
        RUN, SET_HR, SET_MIN, SET_AL_HR, SET_AL_MIN
    } state_t;

    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v, input logic [7:0] top);
        if (v == top) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(
        input logic [7:0] v, input logic [7:0] top);
        if (v == 8'h00) return top;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] bcd_adj(
        input logic [7:0] v, input logic [7:0] top, input logic inc);
        return inc ? bcd_inc(v, top) : bcd_dec(v, top);
    endfunction

    state_t        state;
    logic [PW-1:0] presc;
    logic [7:0]    sec, min, hr, al_min, al_hr;
    logic [7:0]    sec_n, min_n, hr_n, al_min_n, al_hr_n;
    logic          ringing;
    logic [RW-1:0] ring_cnt;
    logic          tick, run, any_btn, step, edit, carry, trigger;
    logic          show_al;
    logic [7:0]    disp_hr, disp_min;

`ifdef SNOOZE_EN
    logic          snz_act;
    logic [7:0]    snz_cnt;
`else
    logic [7:0]    unused_snooze;
    assign unused_snooze = 8'(SNOOZE_MIN);
`endif

    assign tick     = en && (presc == PMAX);
    assign run      = (state == RUN);
    assign any_btn  = mode_btn | up_btn | down_btn;
    // A pulse that lands while ringing only silences the alarm.
    assign step     = mode_btn && !ringing;
    assign edit     = (up_btn ^ down_btn) && !mode_btn && !ringing;
    assign carry    = tick && run && (sec == 8'h59);
    assign trigger  = carry && alarm_en && !mode_btn && !ringing
                   && (min_n == al_min) && (hr_n == al_hr);
    assign show_al  = (state == SET_AL_HR) || (state == SET_AL_MIN);
    assign disp_hr  = show_al ? al_hr : hr;
    assign disp_min = show_al ? al_min : min;

    assign alarm_ring = ringing;
    assign sec_tick   = tick;

    always_comb begin
        sec_n    = sec;
        min_n    = min;
        hr_n     = hr;
        al_min_n = al_min;
        al_hr_n  = al_hr;
        if (tick && run) begin
            sec_n = bcd_inc(sec, 8'h59);
            if (sec == 8'h59) begin
                min_n = bcd_inc(min, 8'h59);
                if (min == 8'h59) hr_n = bcd_inc(hr, 8'h23);
            end
        end
        if (edit) begin
            unique case (state)
                SET_HR:     hr_n     = bcd_adj(hr, 8'h23, up_btn);
                SET_MIN:    min_n    = bcd_adj(min, 8'h59, up_btn);
                SET_AL_HR:  al_hr_n  = bcd_adj(al_hr, 8'h23, up_btn);
                SET_AL_MIN: al_min_n = bcd_adj(al_min, 8'h59, up_btn);
                default: ;
            endcase
        end
        if (step && state == SET_MIN) sec_n = 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            presc    <= '0;
            sec      <= 8'h00;
            min      <= 8'h00;
            hr       <= 8'h00;
            al_min   <= 8'h00;
            al_hr    <= 8'h00;
            ringing  <= 1'b0;
            ring_cnt <= '0;
            digit3   <= 4'd0;
            digit2   <= 4'd0;
            digit1   <= 4'd0;
            digit0   <= 4'd0;
            blink    <= 4'd0;
`ifdef SNOOZE_EN
            snz_act  <= 1'b0;
            snz_cnt  <= 8'd0;
`endif
        end else begin
            if (en) presc <= tick ? '0 : presc + 1'b1;
            sec    <= sec_n;
            min    <= min_n;
            hr     <= hr_n;
            al_min <= al_min_n;
            al_hr  <= al_hr_n;

            if (step) begin
                unique case (state)
                    RUN:       state <= SET_HR;
                    SET_HR:    state <= SET_MIN;
                    SET_MIN:   state <= SET_AL_HR;
                    SET_AL_HR: state <= SET_AL_MIN;
                    default:   state <= RUN;
                endcase
            end

            digit3 <= disp_hr[7:4];
            digit2 <= disp_hr[3:0];
            digit1 <= disp_min[7:4];
            digit0 <= disp_min[3:0];

            unique case (1'b1)
                state == SET_HR,
                state == SET_AL_HR:  blink <= 4'b1100;
                state == SET_MIN,
                state == SET_AL_MIN: blink <= 4'b0011;
                default:             blink <= 4'b0000;
            endcase

            if (ringing) begin
                if (!alarm_en || any_btn) begin
                    ringing <= 1'b0;
`ifdef SNOOZE_EN
                    snz_act <= alarm_en && up_btn
                            && !mode_btn && !down_btn;
                    snz_cnt <= 8'(SNOOZE_MIN);
`endif
                end else if (tick) begin
                    if (ring_cnt == RMAX) ringing <= 1'b0;
                    else ring_cnt <= ring_cnt + 1'b1;
                end
            end else begin
                if (trigger) begin
                    ringing  <= 1'b1;
                    ring_cnt <= '0;
                end
`ifdef SNOOZE_EN
                if (!alarm_en || (step && run)) begin
                    snz_act <= 1'b0;
                end else if (snz_act && carry) begin
                    if (snz_cnt <= 8'd1) begin
                        ringing  <= 1'b1;
                        ring_cnt <= '0;
                        snz_act  <= 1'b0;
                    end else begin
                        snz_cnt <= snz_cnt - 8'd1;
                    end
                end
`endif
            end
        end
    end
endmodule
